// File: rtl/ror_pkg.sv
// Shared definitions for the sequential right shift/rotate engine:
// operation and FSM encodings plus the datapath sizing.
package ror_pkg;
    localparam int WIDTH  = 16;
    localparam int AMT_W  = 4;
    localparam int NSTAGE = AMT_W;
    localparam int SEL_W  = $clog2(NSTAGE);

    typedef enum logic [1:0] {
        OP_ROR  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;
endpackage

// File: rtl/ror_stage.sv
// One log-shifter stage: shifts right by 2^sel when enabled, with the fill
// bits chosen by the operation. Purely combinational.
module ror_stage
    import ror_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  op_t              op,
    output logic [WIDTH-1:0] dout
);
    logic [AMT_W-1:0]   shamt;
    logic [WIDTH-1:0]   fill;
    logic [2*WIDTH-1:0] ext;

    always_comb begin
        shamt = AMT_W'(1) << sel;
        case (op)
            OP_ROR:  fill = data;
            OP_SRA:  fill = {WIDTH{data[WIDTH-1]}};
            default: fill = '0;
        endcase
        // Fill sits above the operand; a window WIDTH wide slid up by shamt
        // is the right shift with the chosen fill entering at the top.
        ext  = {fill, data};
        dout = (en && (op != OP_PASS)) ? ext[shamt +: WIDTH] : data;
    end
endmodule

// File: rtl/ror_seq.sv
// Multi-cycle right shift/rotate unit: one log-shifter stage per clock
// (1, 2, 4, 8), fixed 4-cycle latency, valid/ready on both sides.
module ror_seq
    import ror_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and an offered result stays
    // stable until it transfers.
    state_t           state, state_next;
    logic [SEL_W-1:0] k;
    logic [AMT_W-1:0] amt_q;
    op_t              op_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stage_out;
    logic             load;

    ror_stage u_stage (
        .data (work),
        .sel  (k),
        .en   (amt_q[k]),
        .op   (op_q),
        .dout (stage_out)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (k == SEL_W'(NSTAGE - 1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // Retire and accept can share one edge.
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            amt_q <= '0;
            op_q  <= OP_ROR;
            work  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                work  <= in_data;
                amt_q <= in_amt;
                op_q  <= op_t'(in_op);
                k     <= '0;
            end else if (state == SHIFT) begin
                work <= stage_out;
                k    <= k + SEL_W'(1);
            end
        end
    end

    assign out_data = work;
endmodule
